rca_share_ctrl: RTL
===================

Name: rca_share_ctrl

Overview:
- Round-robin scheduler that shares one external W-bit ripple-carry adder among NREQ word-streaming requesters.
- Each requester's transaction is a multi-word addition, least-significant word first. The controller holds the grant for the whole transaction and chains the carry between words in a register.
- Sits between requester stream interfaces and the combinational adder's a/b/cin/s/cout ports. The output stream carries the sum, carry-out and requester ID.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ) is derived.
- W, 32, adder/word width.
- MAX_WORDS, 4, maximum words per transaction before forced termination (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  NREQ  per-requester word valid
- in_ready  out  NREQ  per-requester word accept
- in_a  in  NREQ*W  operand A words; requester i occupies bits [i*W +: W]
- in_b  in  NREQ*W  operand B words, same packing
- in_cin  in  NREQ  carry-in, sampled on the first word of a transaction only
- in_last  in  NREQ  marks the final word of a transaction
- add_a  out  W  to adder operand A (combinational from the granted requester)
- add_b  out  W  to adder operand B
- add_cin  out  1  to adder carry-in
- add_s  in  W  from adder sum
- add_cout  in  1  from adder carry-out
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accept
- out_sum  out  W  registered sum word
- out_cout  out  1  registered carry-out of this word; meaningful when out_last=1
- out_last  out  1  last word of the transaction
- out_trunc  out  1  transaction was force-terminated at MAX_WORDS
- out_id  out  IDW  ID of the requester that owns the word

Behaviour:
- Clocking and reset: one clock domain (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant=0, carry_q=0, first_q=1, wcnt=0, out_valid=0, out_sum=0, out_cout=0, out_last=0, out_trunc=0, out_id=0.
- in_ready is 0 in IDLE and for every non-granted requester.
- FSM IDLE:
  - If any in_valid is high, grant = first requester with in_valid high, searching from rr_ptr upward with wrap-around.
  - Set first_q=1, wcnt=0, go to BURST.
  - The arbitration decision costs one bubble cycle; no word is accepted in IDLE.
- FSM BURST:
  - Output-register slot free: slot_free = ~out_valid | out_ready.
  - in_ready[grant] = slot_free. A word is accepted when in_valid[grant] & in_ready[grant].
  - Adder drive: add_a/add_b are the granted requester's words; add_cin = first_q ? in_cin[grant] : carry_q.
- On word accept:
  - Capture into the output register: out_sum<=add_s, out_cout<=add_cout, out_id<=grant, out_valid<=1.
  - Update chain state: carry_q<=add_cout, first_q<=0, wcnt<=wcnt+1.
  - Ending test: end = in_last[grant] | (wcnt==MAX_WORDS-1). Set out_last<=end and out_trunc<=end & ~in_last[grant].
  - If end: state<=IDLE, rr_ptr<=grant+1 (mod NREQ).
- Output register:
  - Clears out_valid when out_ready is high and no new word is accepted that cycle.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - Simultaneous drain and accept in the same cycle is allowed, giving 1 word/cycle throughput.
- Latency:
  - Word accepted at cycle t appears on out_* at t+1.
  - First word of a transaction reaches the output no earlier than 2 cycles after in_valid rises, with the requester's word present.
- The granted requester dropping in_valid mid-transaction: the controller waits in BURST with the grant held. There is no timeout.
- After truncation: the requester's subsequent words start a new transaction when that requester next wins arbitration, using in_cin on its first word.
- The adder path is purely combinational; add_* outputs are don't-care outside BURST. They are driven from requester 0 in that case to avoid X propagation.
- rst asserted mid-burst: all state returns to reset values on the next edge. Any pending output word is discarded (out_valid=0).

Optional Feature:
- Macro: RCA_SHARE_CTRL_STATS_EN.
- When defined, adds output ports:
  - stat_txn (16-bit): count of completed transactions, saturating at 0xFFFF.
  - stat_words (32-bit): count of accepted words, saturating.
  - stat_trunc (16-bit): count of truncated transactions, saturating.
- All three counters clear on rst.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Req0, one word a=0xFFFFFFFF, b=0x1, cin=0, last=1 -> out_sum=0x00000000, out_cout=1, out_last=1, out_trunc=0, out_id=0.
- Req2, two words: (a=0xFFFFFFFF, b=0x1, cin=1) then (a=0x0, b=0x0, last=1) -> out_sum 0x00000001 then 0x00000001, out_cout=0 on the last word; the second word uses the chained carry.
- All 4 requesters continuously valid with 1-word transactions, out_ready=1 -> out_id sequence 0,1,2,3,0,1; one bubble cycle between transactions.
- out_ready held low 5 cycles during a 3-word burst -> out_* stable throughout, in_ready[grant]=0 while the slot is full, no words lost or duplicated; all 3 sums are correct after release.
- MAX_WORDS=4, req1 sends 5 words with last only on the 5th -> 4th output has out_last=1 and out_trunc=1; the 5th word is output as a new 1-word transaction using in_cin.
- rst pulsed on the cycle after the 2nd of 4 words is accepted -> next cycle out_valid=0, all in_ready=0, rr_ptr=0; the next request from requester 3 is granted normally.

Source files
------------

// File: rtl/rca_share_ctrl.sv
// Round-robin share of one external ripple-carry adder among NREQ word streams, carry chained per transaction.
// Latency: one arbitration bubble per transaction, then each accepted word is on out_* one cycle later.
// Backpressure: in_ready[grant] follows output-slot availability; output fields hold while out_valid & ~out_ready.
// Optional: define RCA_SHARE_CTRL_STATS_EN to add the stat_txn / stat_words / stat_trunc counters.
module rca_share_ctrl #(
    parameter  int NREQ      = 4,
    parameter  int W         = 32,
    parameter  int MAX_WORDS = 4,
    localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     in_valid,
    output logic [NREQ-1:0]     in_ready,
    input  logic [NREQ*W-1:0]   in_a,
    input  logic [NREQ*W-1:0]   in_b,
    input  logic [NREQ-1:0]     in_cin,
    input  logic [NREQ-1:0]     in_last,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    output logic                add_cin,
    input  logic [W-1:0]        add_s,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_sum,
    output logic                out_cout,
    output logic                out_last,
    output logic                out_trunc,
    output logic [IDW-1:0]      out_id
`ifdef RCA_SHARE_CTRL_STATS_EN
    ,
    output logic [15:0]         stat_txn,
    output logic [31:0]         stat_words,
    output logic [15:0]         stat_trunc
`endif
);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    localparam logic [7:0] LP_WMAX = 8'(MAX_WORDS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant;
    logic [IDW-1:0] w_pick;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_grant_inc;
    logic           r_carry;
    logic           r_first;
    logic [7:0]     r_wcnt;
    logic           w_burst;
    logic           w_slot_free;
    logic           w_accept;
    logic           w_end;
    logic           w_any;

    // First valid requester at or above p, wrapping; lowest k wins because it is written last.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic [IDW-1:0] r;
        int             idx;
        r = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (v[IDW'(idx)]) r = IDW'(idx);
        end
        return r;
    endfunction

    assign w_any       = |in_valid;
    assign w_pick      = rr_pick(in_valid, r_rr_ptr);
    assign w_burst     = (r_state == ST_BURST);
    assign w_slot_free = ~out_valid | out_ready;
    assign w_accept    = w_burst & in_valid[r_grant] & w_slot_free;
    assign w_end       = in_last[r_grant] | (r_wcnt == LP_WMAX);
    assign w_grant_inc = (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

    // Outside a burst the adder is fed from requester 0 so nothing downstream sees X.
    assign w_sel   = w_burst ? r_grant : '0;
    assign add_a   = in_a[w_sel*W +: W];
    assign add_b   = in_b[w_sel*W +: W];
    assign add_cin = w_burst ? (r_first ? in_cin[r_grant] : r_carry) : in_cin[0];

    always_comb begin
        in_ready = '0;
        if (w_burst) in_ready[r_grant] = w_slot_free;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_BURST;
            ST_BURST: if (w_accept && w_end) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_carry  <= 1'b0;
            r_first  <= 1'b1;
            r_wcnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_pick;
                r_first <= 1'b1;
                r_wcnt  <= '0;
            end
            if (w_accept) begin
                r_carry <= add_cout;
                r_first <= 1'b0;
                r_wcnt  <= r_wcnt + 8'd1;
                if (w_end) r_rr_ptr <= w_grant_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_last  <= 1'b0;
            out_trunc <= 1'b0;
            out_id    <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_sum   <= add_s;
            out_cout  <= add_cout;
            out_last  <= w_end;
            out_trunc <= w_end & ~in_last[r_grant];
            out_id    <= r_grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RCA_SHARE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_txn   <= '0;
            stat_words <= '0;
            stat_trunc <= '0;
        end else if (w_accept) begin
            if (stat_words != 32'hFFFF_FFFF) stat_words <= stat_words + 32'd1;
            if (w_end && stat_txn != 16'hFFFF) stat_txn <= stat_txn + 16'd1;
            if (w_end && !in_last[r_grant] && stat_trunc != 16'hFFFF)
                stat_trunc <= stat_trunc + 16'd1;
        end
    end
`endif

endmodule
